prbs_ber_checker: RTL and testbench

PRBS_BER_CHECKER -- requirements
Module: prbs_ber_checker

---
 rtl/prbs_ber_checker.sv | 156 +++++++++++++++
 tb/tb_prbs_ber_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_ber_checker.sv
// PRBS bit-error-rate checker: self-synchronises an LFSR to the received stream,
// then counts bit errors overall and per fixed-length measurement window.
module prbs_ber_checker #(
  parameter int                  LFSR_LEN    = 7,
  parameter logic [LFSR_LEN-1:0] TAPS        = 7'b1100000,
  parameter int                  LOCK_THRESH = 16,
  parameter int                  UNLOCK_ERR  = 8,
  parameter int                  WINDOW_BITS = 1024,
  parameter int                  CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             data_i,
  input  logic             clr,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             window_done,
  output logic [CNT_W-1:0] win_err
);

  localparam logic [1:0] S_SEED   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int SEED_W  = $clog2(LFSR_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int WB_W    = $clog2(WINDOW_BITS + 1);
  localparam int WE_W    = WB_W;
  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned UNLOCK_U = 64'(UNLOCK_ERR);

  logic [1:0]          state;
  logic [SEED_W-1:0]   seed_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [LFSR_LEN-1:0] lfsr;
  logic [WB_W-1:0]     win_bits;
  logic [WE_W-1:0]     win_errs;

  logic                p;
  logic                mis;
  logic [WE_W-1:0]     werr_next;
  logic [WB_W-1:0]     wbits_next;
  logic                resync;
  logic                win_end;

  assign p          = ^(lfsr & TAPS);
  assign mis        = data_i ^ p;
  assign werr_next  = win_errs + WE_W'(mis);
  assign wbits_next = win_bits + 1'b1;
  assign resync     = (UNLOCK_ERR != 0) && (64'(werr_next) == UNLOCK_U);
  assign win_end    = (wbits_next == WB_W'(WINDOW_BITS));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_win(input logic [WE_W-1:0] v);
    if (64'(v) > CNT_MAX) return '1;
    return CNT_W'(v);
  endfunction

  // Acquisition FSM and reference LFSR. Once past SEED the LFSR free-runs on its
  // own prediction, so a channel error never corrupts later predictions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      lfsr      <= '0;
      locked    <= 1'b0;
    end else if (bit_en) begin
      case (state)
        S_SEED: begin
          lfsr <= {lfsr[LFSR_LEN-2:0], data_i};
          if (seed_cnt == SEED_W'(LFSR_LEN - 1)) begin
            state     <= S_VERIFY;
            seed_cnt  <= '0;
            match_cnt <= '0;
          end else begin
            seed_cnt <= seed_cnt + 1'b1;
          end
        end
        S_VERIFY: begin
          lfsr <= {lfsr[LFSR_LEN-2:0], p};
          // An all-zero register would "predict" a stuck-at-0 line forever.
          if (mis || (lfsr == '0)) begin
            state    <= S_SEED;
            seed_cnt <= '0;
          end else if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end
        S_LOCKED: begin
          lfsr <= {lfsr[LFSR_LEN-2:0], p};
          if (resync) begin
            state    <= S_SEED;
            seed_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state  <= S_SEED;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_err     <= 1'b0;
      window_done <= 1'b0;
      bit_count   <= '0;
      err_count   <= '0;
      win_err     <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
    end else begin
      bit_err     <= 1'b0;
      window_done <= 1'b0;
      if (bit_en && state == S_LOCKED) begin
        bit_err   <= mis;
        bit_count <= sat_inc(bit_count);
        if (mis) err_count <= sat_inc(err_count);
        if (resync) begin
          win_bits <= '0;
          win_errs <= '0;
        end else if (win_end) begin
          window_done <= 1'b1;
          win_err     <= sat_win(werr_next);
          win_bits    <= '0;
          win_errs    <= '0;
        end else begin
          win_bits <= wbits_next;
          win_errs <= werr_next;
        end
      end
      // NOTE: the last non-blocking assignment in the block wins, so clr
      // overrides any counter update above while bit_err still pulses.
      if (clr) begin
        bit_count <= '0;
        err_count <= '0;
        win_err   <= '0;
        win_bits  <= '0;
        win_errs  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: directed segment table, hand-written reset/stuck-line
// sequences and a randomized phase, all checked against a bit-history model.
module tb_prbs_ber_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_en = 1'b0;
  logic data_i = 1'b0;
  logic clr = 1'b0;

  logic        locked_a, bit_err_a, window_done_a;
  logic [15:0] bit_count_a, err_count_a, win_err_a;
  logic        locked_b, bit_err_b, window_done_b;
  logic [3:0]  bit_count_b, err_count_b, win_err_b;

  always #5 clk = ~clk;

  prbs_ber_checker dut_a (
    .clk(clk), .rst(rst), .bit_en(bit_en), .data_i(data_i), .clr(clr),
    .locked(locked_a), .bit_err(bit_err_a), .bit_count(bit_count_a),
    .err_count(err_count_a), .window_done(window_done_a), .win_err(win_err_a)
  );

  prbs_ber_checker #(.CNT_W(4), .UNLOCK_ERR(0), .WINDOW_BITS(32)) dut_b (
    .clk(clk), .rst(rst), .bit_en(bit_en), .data_i(data_i), .clr(clr),
    .locked(locked_b), .bit_err(bit_err_b), .bit_count(bit_count_b),
    .err_count(err_count_b), .window_done(window_done_b), .win_err(win_err_b)
  );

  typedef struct {
    int       len;
    bit [31:0] taps;
    int       thresh;
    int       unlock;
    int       window;
    longint   cnt_max;
  } cfg_t;

  // hist[k-1] is the reference bit from k strobes ago.
  typedef struct {
    int        phase;     // 0 acquiring, 1 verifying, 2 tracking
    int        progress;  // seed bits taken or matches seen
    bit [31:0] hist;
    longint    bits;
    longint    errs;
    longint    win_last;
    int        wbits;
    int        werrs;
    bit        locked;
    bit        bit_err;
    bit        wdone;
  } model_t;

  typedef struct {
    string name;
    int    strobes;
    int    inv_first;
    int    inv_step;
    int    inv_count;
    bit    clr_first;
    int    e_locked;
    int    e_bits;
    int    e_errs;
    int    e_bit_err;
    int    e_wdone;
    int    e_win_err;
    int    e_s_locked;
    int    e_s_errs;
    int    e_s_bits;
  } seg_t;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     src[127];
  int     src_idx = 0;
  cfg_t   ca, cb;
  model_t ma, mb;
  seg_t   segs[14];

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.progress = 0; m.hist = '0;
    m.bits = 0; m.errs = 0; m.win_last = 0; m.wbits = 0; m.werrs = 0;
    m.locked = 0; m.bit_err = 0; m.wdone = 0;
    return m;
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic model_t step(model_t m, cfg_t c, bit en, bit d, bit cl);
    bit pred;
    bit zero;
    bit miss;
    m.bit_err = 0;
    m.wdone   = 0;
    if (en) begin
      pred = 0;
      zero = 1;
      for (int k = 0; k < c.len; k++) begin
        if (c.taps[k]) pred ^= m.hist[k];
        if (m.hist[k]) zero = 0;
      end
      if (m.phase == 0) begin
        m.hist = {m.hist[30:0], d};
        m.progress++;
        if (m.progress == c.len) begin
          m.phase = 1;
          m.progress = 0;
        end
      end else if (m.phase == 1) begin
        m.hist = {m.hist[30:0], pred};
        if (d != pred || zero) begin
          m.phase = 0;
          m.progress = 0;
        end else begin
          m.progress++;
          if (m.progress == c.thresh) m.phase = 2;
        end
      end else begin
        m.hist = {m.hist[30:0], pred};
        miss = (d != pred);
        m.bits = sat(m.bits + 1, c.cnt_max);
        if (miss) begin
          m.errs = sat(m.errs + 1, c.cnt_max);
          m.werrs++;
          m.bit_err = 1;
        end
        m.wbits++;
        if (c.unlock != 0 && m.werrs >= c.unlock) begin
          m.phase = 0; m.progress = 0; m.wbits = 0; m.werrs = 0;
        end else if (m.wbits == c.window) begin
          m.wdone = 1;
          m.win_last = sat(m.werrs, c.cnt_max);
          m.wbits = 0; m.werrs = 0;
        end
      end
    end
    if (cl) begin
      m.bits = 0; m.errs = 0; m.win_last = 0; m.wbits = 0; m.werrs = 0;
    end
    m.locked = (m.phase == 2);
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (t=%0t): got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("a.locked",      64'(locked_a),      64'(ma.locked));
    check("a.bit_err",     64'(bit_err_a),     64'(ma.bit_err));
    check("a.bit_count",   64'(bit_count_a),   64'(ma.bits));
    check("a.err_count",   64'(err_count_a),   64'(ma.errs));
    check("a.window_done", 64'(window_done_a), 64'(ma.wdone));
    check("a.win_err",     64'(win_err_a),     64'(ma.win_last));
    check("b.locked",      64'(locked_b),      64'(mb.locked));
    check("b.bit_err",     64'(bit_err_b),     64'(mb.bit_err));
    check("b.bit_count",   64'(bit_count_b),   64'(mb.bits));
    check("b.err_count",   64'(err_count_b),   64'(mb.errs));
    check("b.window_done", 64'(window_done_b), 64'(mb.wdone));
    check("b.win_err",     64'(win_err_b),     64'(mb.win_last));
  endtask

  // One clock: inputs change on the falling edge, outputs are read 1 time unit
  // after the rising edge.
  task automatic apply(input bit en, input bit inv, input bit cl);
    bit d;
    @(negedge clk);
    if (en) begin
      d = src[src_idx] ^ inv;
      src_idx = (src_idx + 1) % 127;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    bit_en = en;
    data_i = d;
    clr    = cl;
    @(posedge clk);
    #1;
    ma = step(ma, ca, en, d, cl);
    mb = step(mb, cb, en, d, cl);
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    bit_en = 1'b0;
    clr    = 1'b0;
    rst    = 1'b0;
    #1;
    ma = model_reset();
    mb = model_reset();
    compare_all();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare_all();
    check("reset locked released", 64'(locked_a), 64'd0);
  endtask

  initial begin : main
    int  off;
    bit  inv;
    bit  en;
    int  err_div;

    ca = '{7, 32'h60, 16, 8, 1024, 64'd65535};
    cb = '{7, 32'h60, 16, 0, 32, 64'd15};

    // Clean PRBS7 source: b[n] = b[n-7] ^ b[n-6].
    src[0] = 1'b1;
    for (int i = 1; i < 7; i++) src[i] = 1'b0;
    for (int i = 7; i < 127; i++) src[i] = src[i-7] ^ src[i-6];

    //         name          strb  if is ic clr  lk  bits  errs be wd  we  slk se sb
    segs[0]  = '{"acquire",     22, 0, 1, 0, 0,   0,    0,   0, -1, -1, -1, -1, -1, -1};
    segs[1]  = '{"lock_edge",    1, 0, 1, 0, 0,   1,    0,   0, -1, -1, -1,  1, -1, -1};
    segs[2]  = '{"clean_1000", 1000, 0, 1, 0, 0,   1, 1000,   0,  0,  0,  0, -1, -1, -1};
    segs[3]  = '{"one_err",      1, 0, 1, 1, 0,   1, 1001,   1,  1, -1, -1, -1, -1, -1};
    segs[4]  = '{"err_gone",     1, 0, 1, 0, 0,   1, 1002,   1,  0, -1, -1, -1, -1, -1};
    segs[5]  = '{"win_fill",    22, 5, 10, 2, 0,  1, 1024,   3, -1,  1,  3, -1, -1, -1};
    segs[6]  = '{"win_next",     1, 0, 1, 0, 0,   1, 1025,   3, -1,  0,  3, -1, -1, -1};
    segs[7]  = '{"win_clean", 1023, 0, 1, 0, 0,   1, 2048,   3, -1,  1,  0, -1, -1, -1};
    segs[8]  = '{"burst7",      14, 1, 2, 7, 0,   1, 2062,  10, -1, -1, -1, -1, -1, -1};
    segs[9]  = '{"burst8",       2, 1, 1, 1, 0,   0, 2064,  11, -1, -1,  0,  1, -1, -1};
    segs[10] = '{"relock_22",   22, 0, 1, 0, 0,   0, 2064,  11, -1, -1, -1, -1, -1, -1};
    segs[11] = '{"relock_23",    1, 0, 1, 0, 0,   1, -1,    -1, -1, -1,  0, -1, -1, -1};
    segs[12] = '{"clr_strobe",   1, 0, 1, 0, 1,   1,    0,   0, -1, -1,  0,  1,  0,  0};
    segs[13] = '{"sat_errs",    40, 0, 2, 20, 0, -1, -1,    -1, -1, -1, -1,  1, 15, 15};

    ma = model_reset();
    mb = model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    for (int s = 0; s < 14; s++) begin
      for (int i = 0; i < segs[s].strobes; i++) begin
        off = i - segs[s].inv_first;
        inv = (off >= 0) && (off % segs[s].inv_step == 0) &&
              (off / segs[s].inv_step < segs[s].inv_count);
        apply(1'b1, inv, segs[s].clr_first && (i == 0));
      end
      if (segs[s].e_locked >= 0)
        check({segs[s].name, " locked"}, 64'(locked_a), 64'(segs[s].e_locked));
      if (segs[s].e_bits >= 0)
        check({segs[s].name, " bit_count"}, 64'(bit_count_a), 64'(segs[s].e_bits));
      if (segs[s].e_errs >= 0)
        check({segs[s].name, " err_count"}, 64'(err_count_a), 64'(segs[s].e_errs));
      if (segs[s].e_bit_err >= 0)
        check({segs[s].name, " bit_err"}, 64'(bit_err_a), 64'(segs[s].e_bit_err));
      if (segs[s].e_wdone >= 0)
        check({segs[s].name, " window_done"}, 64'(window_done_a), 64'(segs[s].e_wdone));
      if (segs[s].e_win_err >= 0)
        check({segs[s].name, " win_err"}, 64'(win_err_a), 64'(segs[s].e_win_err));
      if (segs[s].e_s_locked >= 0)
        check({segs[s].name, " small locked"}, 64'(locked_b), 64'(segs[s].e_s_locked));
      if (segs[s].e_s_errs >= 0)
        check({segs[s].name, " small err_count"}, 64'(err_count_b), 64'(segs[s].e_s_errs));
      if (segs[s].e_s_bits >= 0)
        check({segs[s].name, " small bit_count"}, 64'(bit_count_b), 64'(segs[s].e_s_bits));
    end

    // Random strobe gaps, sparse then dense errors, occasional clears.
    for (int c = 0; c < 3000; c++) begin
      err_div = (c < 1500) ? 300 : 20;
      en  = ($urandom_range(0, 9) < 7);
      inv = ($urandom_range(0, err_div - 1) == 0);
      apply(en, inv, $urandom_range(0, 249) == 0);
    end

    // Mid-stream reset, then a stuck-at-0 line must never lock either checker.
    do_reset(3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bit_en = 1'b1;
      data_i = 1'b0;
      clr    = 1'b0;
      @(posedge clk);
      #1;
      ma = step(ma, ca, 1'b1, 1'b0, 1'b0);
      mb = step(mb, cb, 1'b1, 1'b0, 1'b0);
      compare_all();
    end
    check("stuck0 locked", 64'(locked_a), 64'd0);
    check("stuck0 small locked", 64'(locked_b), 64'd0);

    // A clean stream after reset locks on exactly the 23rd strobe.
    do_reset(3);
    for (int i = 0; i < 22; i++) apply(1'b1, 1'b0, 1'b0);
    check("post-reset 22 locked", 64'(locked_a), 64'd0);
    apply(1'b1, 1'b0, 1'b0);
    check("post-reset 23 locked", 64'(locked_a), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
